// File: rtl/life_event_sequencer.sv
// Purpose : player life/HP controller; arbitrates start/kill/hit/bonus requests,
//           owns the lives register, and sequences IDLE/PLAY/HIT_COOL/GAME_OVER.
// Latency : one cycle; a request sampled at edge N shows on the registered outputs after edge N.
// Backpr. : none; requests that lose same-cycle arbitration or arrive in an ignoring state are dropped.
// Ports   : clk, resetN (async, active-low); start_game, hit_req, kill_req, bonus_req,
//           one_sec_pulse in; lives, invulnerable, game_over, life_lost, life_gained,
//           player_visible, state (IDLE=0, PLAY=1, HIT_COOL=2, GAME_OVER=3) out.
// Option  : define LIFE_BLINK_EN to blink player_visible during HIT_COOL every BLINK_CYCLES clocks.
module life_event_sequencer #(
  parameter int LIFE_W       = 4,
  parameter int INIT_LIVES   = 3,
  parameter int MAX_LIVES    = 9,
  parameter int INVULN_SECS  = 2,
  parameter int BLINK_CYCLES = 6250000
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              start_game,
  input  logic              hit_req,
  input  logic              kill_req,
  input  logic              bonus_req,
  input  logic              one_sec_pulse,
  output logic [LIFE_W-1:0] lives,
  output logic              invulnerable,
  output logic              game_over,
  output logic              life_lost,
  output logic              life_gained,
  output logic              player_visible,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    HIT_COOL  = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(INVULN_SECS + 1);
  localparam logic [LIFE_W-1:0] INIT_L = LIFE_W'(INIT_LIVES);
  localparam logic [LIFE_W-1:0] MAX_L  = LIFE_W'(MAX_LIVES);
  localparam logic [CNT_W-1:0]  COOL_L = CNT_W'(INVULN_SECS);

  // Elaboration-time parameter sanity check.
  generate
    if (INIT_LIVES < 1 || MAX_LIVES < INIT_LIVES || MAX_LIVES > (2**LIFE_W - 1) ||
        INVULN_SECS < 1 || BLINK_CYCLES < 1) begin : g_bad_param
      $error("life_event_sequencer: illegal parameter combination");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [LIFE_W-1:0] lives_q, lives_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              life_lost_q, life_lost_d;
  logic              life_gained_q, life_gained_d;
  logic              invulnerable_q, invulnerable_d;
  logic              game_over_q, game_over_d;
  logic              visible_q, visible_d;

`ifdef LIFE_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
  logic [BLINK_W-1:0] blink_q, blink_d;
`endif

  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    cnt_d         = cnt_q;
    life_lost_d   = 1'b0;
    life_gained_d = 1'b0;

    case (state_q)
      IDLE, GAME_OVER: begin
        if (start_game) begin
          state_d = PLAY;
          lives_d = INIT_L;
        end
      end

      PLAY: begin
        if (kill_req) begin
          lives_d     = '0;
          life_lost_d = 1'b1;
          state_d     = GAME_OVER;
        end else if (hit_req) begin
          life_lost_d = 1'b1;
          if (lives_q >= LIFE_W'(2)) begin
            lives_d = lives_q - LIFE_W'(1);
            cnt_d   = COOL_L;
            state_d = HIT_COOL;
          end else begin
            lives_d = '0;
            state_d = GAME_OVER;
          end
        end else if (bonus_req && (lives_q < MAX_L)) begin
          lives_d       = lives_q + LIFE_W'(1);
          life_gained_d = 1'b1;
        end
      end

      HIT_COOL: begin
        if (kill_req) begin
          lives_d     = '0;
          life_lost_d = 1'b1;
          cnt_d       = '0;
          state_d     = GAME_OVER;
        end else begin
          // hit_req is ignored here, so it does not block a same-cycle bonus.
          if (bonus_req && (lives_q < MAX_L)) begin
            lives_d       = lives_q + LIFE_W'(1);
            life_gained_d = 1'b1;
          end
          // The hit cycle itself is spent in PLAY, so a tick there is never counted.
          if (one_sec_pulse) begin
            if (cnt_q <= CNT_W'(1)) begin
              cnt_d   = '0;
              state_d = PLAY;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    invulnerable_d = (state_d == HIT_COOL);
    game_over_d    = (state_d == GAME_OVER);

`ifdef LIFE_BLINK_EN
    blink_d = '0;
    if (state_d == HIT_COOL) begin
      if (state_q != HIT_COOL) begin
        // Entry edge: hide the sprite and restart the divider.
        visible_d = 1'b0;
        blink_d   = '0;
      end else if (blink_q == BLINK_W'(BLINK_CYCLES - 1)) begin
        visible_d = ~visible_q;
        blink_d   = '0;
      end else begin
        visible_d = visible_q;
        blink_d   = blink_q + BLINK_W'(1);
      end
    end else begin
      visible_d = (state_d != GAME_OVER);
    end
`else
    visible_d = (state_d != GAME_OVER);
`endif
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= IDLE;
      lives_q        <= INIT_L;
      cnt_q          <= '0;
      life_lost_q    <= 1'b0;
      life_gained_q  <= 1'b0;
      invulnerable_q <= 1'b0;
      game_over_q    <= 1'b0;
      visible_q      <= 1'b1;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      cnt_q          <= cnt_d;
      life_lost_q    <= life_lost_d;
      life_gained_q  <= life_gained_d;
      invulnerable_q <= invulnerable_d;
      game_over_q    <= game_over_d;
      visible_q      <= visible_d;
    end
  end

`ifdef LIFE_BLINK_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end
`endif

  assign lives          = lives_q;
  assign invulnerable   = invulnerable_q;
  assign game_over      = game_over_q;
  assign life_lost      = life_lost_q;
  assign life_gained    = life_gained_q;
  assign player_visible = visible_q;
  assign state          = state_q;

endmodule

// File: tb/tb_life_event_sequencer.sv
// Purpose : self-checking bench for life_event_sequencer (default build, feature macro undefined).
// Latency : outputs checked 1 time unit after each rising edge.
// Backpr. : none.
module tb_life_event_sequencer;

  localparam int LIFE_W = 4;
  localparam int INIT   = 3;
  localparam int MAXL   = 9;
  localparam int INVS   = 2;

  logic              clk;
  logic              resetN;
  logic              start_game, hit_req, kill_req, bonus_req, one_sec_pulse;
  logic [LIFE_W-1:0] lives;
  logic              invulnerable, game_over, life_lost, life_gained, player_visible;
  logic [1:0]        state;

  int total = 0;
  int bad   = 0;

  life_event_sequencer dut (
    .clk            (clk),
    .resetN         (resetN),
    .start_game     (start_game),
    .hit_req        (hit_req),
    .kill_req       (kill_req),
    .bonus_req      (bonus_req),
    .one_sec_pulse  (one_sec_pulse),
    .lives          (lives),
    .invulnerable   (invulnerable),
    .game_over      (game_over),
    .life_lost      (life_lost),
    .life_gained    (life_gained),
    .player_visible (player_visible),
    .state          (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compares every output against an expected state/lives/pulse triple;
  // invulnerable, game_over and visibility follow from the state.
  task automatic check_all(input string tag, input int st, input int lv,
                           input int lost, input int gain);
    check({tag, ".state"}, int'(state), st);
    check({tag, ".lives"}, int'(lives), lv);
    check({tag, ".life_lost"}, int'(life_lost), lost);
    check({tag, ".life_gained"}, int'(life_gained), gain);
    check({tag, ".invulnerable"}, int'(invulnerable), (st == 2) ? 1 : 0);
    check({tag, ".game_over"}, int'(game_over), (st == 3) ? 1 : 0);
    check({tag, ".visible"}, int'(player_visible), (st == 3) ? 0 : 1);
  endtask

  task automatic drive(input logic s, input logic h, input logic k,
                       input logic b, input logic t);
    start_game    = s;
    hit_req       = h;
    kill_req      = k;
    bonus_req     = b;
    one_sec_pulse = t;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic s, h, k, b, t;
    int   st, lv, lost, gain;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic h, input logic k,
                              input logic b, input logic t,
                              input int st, input int lv, input int lost, input int gain);
    vec_t v;
    v.s = s; v.h = h; v.k = k; v.b = b; v.t = t;
    v.st = st; v.lv = lv; v.lost = lost; v.gain = gain;
    return v;
  endfunction

  // Reference model: modes 0 idle, 1 play, 2 cooldown, 3 over.
  int m_mode, m_lives, m_secs_left;

  task automatic model_reset;
    m_mode      = 0;
    m_lives     = INIT;
    m_secs_left = 0;
  endtask

  task automatic model_step(input logic s, input logic h, input logic k,
                            input logic b, input logic t,
                            output int lost, output int gain);
    lost = 0;
    gain = 0;
    if (m_mode == 0 || m_mode == 3) begin
      if (s) begin
        m_mode  = 1;
        m_lives = INIT;
      end
    end else if (k) begin
      m_lives = 0;
      lost    = 1;
      m_mode  = 3;
    end else if (m_mode == 1 && h) begin
      lost    = 1;
      m_lives = m_lives - 1;
      if (m_lives == 0) m_mode = 3;
      else begin
        m_mode      = 2;
        m_secs_left = INVS;
      end
    end else begin
      if (b && m_lives < MAXL) begin
        m_lives = m_lives + 1;
        gain    = 1;
      end
      if (m_mode == 2 && t) begin
        m_secs_left = m_secs_left - 1;
        if (m_secs_left == 0) m_mode = 1;
      end
    end
  endtask

  vec_t tbl[30];

  initial begin
    int lost, gain;

    // Stimulus table: {start,hit,kill,bonus,tick} -> {state,lives,lost,gained}
    tbl[0]  = mk(0,1,0,0,0, 0,3,0,0);  // hit ignored in IDLE
    tbl[1]  = mk(0,0,0,1,0, 0,3,0,0);  // bonus ignored in IDLE
    tbl[2]  = mk(1,0,0,0,0, 1,3,0,0);
    tbl[3]  = mk(0,1,0,0,0, 2,2,1,0);  // first hit
    tbl[4]  = mk(0,1,0,0,1, 2,2,0,0);  // held hit ignored, tick 2->1
    tbl[5]  = mk(0,1,0,0,0, 2,2,0,0);
    tbl[6]  = mk(0,1,0,0,1, 1,2,0,0);  // tick 1->0, back to PLAY
    tbl[7]  = mk(0,1,0,0,0, 2,1,1,0);  // still-held hit accepted
    tbl[8]  = mk(0,0,0,0,1, 2,1,0,0);
    tbl[9]  = mk(0,0,0,1,1, 1,2,0,1);  // bonus in cooldown + exit tick
    tbl[10] = mk(0,1,0,1,0, 2,1,1,0);  // hit beats bonus
    tbl[11] = mk(0,0,0,0,1, 2,1,0,0);
    tbl[12] = mk(0,0,0,0,1, 1,1,0,0);
    tbl[13] = mk(0,1,0,0,0, 3,0,1,0);  // last life lost
    tbl[14] = mk(0,1,1,1,0, 3,0,0,0);  // all ignored in GAME_OVER
    tbl[15] = mk(1,0,0,0,0, 1,3,0,0);
    tbl[16] = mk(0,1,1,0,0, 3,0,1,0);  // kill beats hit
    tbl[17] = mk(1,0,0,0,0, 1,3,0,0);
    tbl[18] = mk(0,0,0,1,0, 1,4,0,1);
    tbl[19] = mk(0,0,0,1,0, 1,5,0,1);
    tbl[20] = mk(0,0,0,1,0, 1,6,0,1);
    tbl[21] = mk(0,0,0,1,0, 1,7,0,1);
    tbl[22] = mk(0,0,0,1,0, 1,8,0,1);
    tbl[23] = mk(0,0,0,1,0, 1,9,0,1);
    tbl[24] = mk(0,0,0,1,0, 1,9,0,0);  // saturated
    tbl[25] = mk(0,1,0,0,0, 2,8,1,0);
    tbl[26] = mk(0,0,0,1,0, 2,9,0,1);  // bonus in cooldown
    tbl[27] = mk(0,0,0,1,0, 2,9,0,0);
    tbl[28] = mk(0,0,1,0,0, 3,0,1,0);  // kill honoured in cooldown
    tbl[29] = mk(1,0,1,0,0, 1,3,0,0);  // start beats kill in GAME_OVER

    resetN = 1'b0;
    drive(0,0,0,0,0);
    #12;
    check_all("reset", 0, INIT, 0, 0);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].s, tbl[i].h, tbl[i].k, tbl[i].b, tbl[i].t);
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].lv, tbl[i].lost, tbl[i].gain);
    end

    // Asynchronous reset in the middle of the cooldown window.
    drive(0,1,0,0,0);
    tick();
    check_all("pre_rst", 2, 2, 1, 0);
    drive(0,0,0,0,0);
    #2;
    resetN = 1'b0;
    #1;
    check_all("async_rst", 0, INIT, 0, 0);
    tick();
    check_all("rst_hold", 0, INIT, 0, 0);
    resetN = 1'b1;

    // start_game has no effect once a game is running.
    drive(1,0,0,0,0);
    tick();
    check_all("start", 1, 3, 0, 0);
    drive(0,0,0,1,0);
    tick();
    check_all("bonus4", 1, 4, 0, 0 + 1);
    drive(1,0,0,0,0);
    tick();
    check_all("restart_in_play", 1, 4, 0, 0);

    // Randomized run against the reference model.
    drive(0,0,0,0,0);
    #2;
    resetN = 1'b0;
    #1;
    resetN = 1'b1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic s, h, k, b, t;
      s = ($urandom_range(0, 99) < 4);
      k = ($urandom_range(0, 99) < 3);
      h = ($urandom_range(0, 99) < 25);
      b = ($urandom_range(0, 99) < 20);
      t = ($urandom_range(0, 99) < 30);
      drive(s, h, k, b, t);
      tick();
      model_step(s, h, k, b, t, lost, gain);
      check_all($sformatf("rnd%0d", n), m_mode, m_lives, lost, gain);
    end

    drive(0,0,0,0,0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/life_event_sequencer.md
Name: life_event_sequencer

Overview:
Central controller for the player's life/HP resource. It arbitrates same-cycle damage, instant-kill and bonus requests from the collision and scoring logic, and owns the lives register. It sequences the post-hit invulnerability window, timed by the shared one-second tick, and the IDLE/PLAY/GAME_OVER flow. The game-over, lives and visibility outputs drive the HUD digit, the player sprite and the top-level game FSM.

Parameters:
LIFE_W, 4, width of the lives register
INIT_LIVES, 3, lives loaded at reset and at every game start; must be >= 1
MAX_LIVES, 9, saturation ceiling for bonuses; INIT_LIVES <= MAX_LIVES <= 2^LIFE_W-1
INVULN_SECS, 2, post-hit invulnerability length in one_sec_pulse ticks; must be >= 1
BLINK_CYCLES, 6250000, clk cycles per visibility toggle; used only with the optional feature

Ports:
clk  in  1  system clock
resetN  in  1  reset (see Behaviour)
start_game  in  1  one-cycle pulse; starts or restarts a game
hit_req  in  1  level/pulse; collision damage request
kill_req  in  1  level/pulse; instant-death request (hazard, timer expiry)
bonus_req  in  1  one-cycle pulse; extra-life pickup
one_sec_pulse  in  1  one-cycle tick, once per second
lives  out  LIFE_W  current lives; drives the HUD
invulnerable  out  1  high while in HIT_COOL
game_over  out  1  high while in GAME_OVER
life_lost  out  1  one-cycle pulse per accepted hit or kill
life_gained  out  1  one-cycle pulse per accepted bonus that incremented lives
player_visible  out  1  sprite enable
state  out  2  IDLE=0, PLAY=1, HIT_COOL=2, GAME_OVER=3; debug/top FSM

Behaviour:
- Reset: resetN is asynchronous, active-low; clock is clk. On reset: state=IDLE, lives=INIT_LIVES, invulnerable=0, game_over=0, life_lost=0, life_gained=0, player_visible=1, cooldown counter=0.
- All outputs are registered. A request sampled at edge N is reflected on the outputs after edge N.
- Same-cycle priority: start_game (in IDLE/GAME_OVER only) > kill_req > hit_req > bonus_req. A lower-priority request in the same cycle is dropped, not queued.
- IDLE:
  - hit, kill and bonus are ignored.
  - start_game -> PLAY, lives=INIT_LIVES.
- PLAY:
  - kill_req -> lives=0, life_lost=1, GAME_OVER.
  - hit_req with lives>=2 -> lives-1, life_lost=1, load cooldown counter with INVULN_SECS, HIT_COOL.
  - hit_req with lives==1 -> lives=0, life_lost=1, GAME_OVER.
  - bonus_req -> if lives<MAX_LIVES: lives+1, life_gained=1. At MAX_LIVES, lives are unchanged and there is no pulse.
- HIT_COOL:
  - invulnerable=1; hit_req is ignored, so a held hit_req never causes a second decrement.
  - kill_req is still honoured: lives=0, GAME_OVER.
  - bonus_req is accepted exactly as in PLAY.
  - Each one_sec_pulse decrements the counter. A pulse arriving in the entry cycle is not counted.
  - On the pulse that takes the counter 1->0, go to PLAY. The window therefore spans between INVULN_SECS-1 and INVULN_SECS seconds.
  - If hit_req is still high in the first PLAY cycle, it is accepted as a new hit.
- GAME_OVER:
  - game_over=1; lives hold 0; hit, kill and bonus are ignored.
  - start_game -> lives=INIT_LIVES, PLAY.
- Arithmetic: lives never underflows below 0 and never exceeds MAX_LIVES.
- life_lost and life_gained are never high in the same cycle.
- Reset mid-HIT_COOL or mid-GAME_OVER returns immediately to IDLE with reset values.

Optional Feature:
LIFE_BLINK_EN
- Defined:
  - In HIT_COOL, player_visible toggles every BLINK_CYCLES clk cycles. It goes to 0 on the entry edge and the blink divider restarts on entry.
  - player_visible is forced to 1 on the exit edge to PLAY.
  - player_visible is 0 in GAME_OVER and 1 in IDLE/PLAY.
- Undefined:
  - player_visible=0 in GAME_OVER, 1 in every other state.
  - The blink divider and the BLINK_CYCLES logic are not synthesised.

Test Plan:
1. Reset, then start_game; one hit_req pulse -> lives 3->2, life_lost for 1 cycle, invulnerable=1, state=2.
2. In HIT_COOL, hold hit_req high for 3 one_sec_pulse ticks (INVULN_SECS=2) -> lives stay 2 during cooldown. Return to PLAY after the 2nd tick, then the held hit is taken: lives=1, HIT_COOL re-entered.
3. lives=1 in PLAY, hit_req -> lives=0, game_over=1, state=3. Further hit/bonus ignored. start_game -> lives=3, state=1.
4. Same-cycle hit_req+bonus_req with lives=3 -> lives=2, life_lost=1, life_gained=0. Same-cycle kill_req+hit_req -> lives=0, GAME_OVER.
5. Seven bonus_req pulses from lives=3 (MAX_LIVES=9) -> lives=9. Six life_gained pulses, the seventh has no pulse and lives stay 9. A bonus during HIT_COOL increments lives.
6. Assert resetN low mid-HIT_COOL -> state=0, lives=3, invulnerable=0 immediately. With LIFE_BLINK_EN and BLINK_CYCLES=4, player_visible in HIT_COOL reads 0,0,0,0,1,1,1,1,... from entry.
